mult_secuencial_shift_add: RTL and testbench

// Sequential shift-and-add unsigned multiplier. Sits directly downstream of the

---
 rtl/mult_secuencial_shift_add.sv | 90 +++++++++
 tb/tb_mult_secuencial_shift_add.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial_shift_add.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// constant WIDTH+1 clock latency from start to the completion pulse.
module mult_secuencial_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
    output logic [2*WIDTH-1:0]   producto,
    output logic                 listo,
    output logic                 ocupado
);

    // state | meaning
    // IDLE  | waiting for inicio; operands sampled on the accepting edge
    // CALC  | WIDTH add/shift iterations, one per clock
    // DONE  | product copied to producto, listo pulsed, back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_sum;

    // Carry lives in w_sum[WIDTH]; after the right shift it is always cleared,
    // so it never needs its own register.
    always_comb begin
        w_sum = {1'b0, r_a};
        if (r_q[0]) begin
            w_sum = {1'b0, r_a} + {1'b0, r_m};
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_m      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_count  <= '0;
            producto <= '0;
            listo    <= 1'b0;
            ocupado  <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (inicio) begin
                        r_m     <= multiplicando;
                        r_q     <= multiplicador;
                        r_a     <= '0;
                        r_count <= '0;
                        ocupado <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a     <= w_sum[WIDTH:1];
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    producto <= {r_a, r_q};
                    listo    <= 1'b1;
                    ocupado  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_secuencial_shift_add.sv
// Scoreboard bench for the shift-and-add multiplier: stimulus pushes expected
// product and completion cycle, a negedge monitor pops on every listo.
module tb_mult_secuencial_shift_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [7:0]  multiplicando;
    logic [7:0]  multiplicador;
    logic [15:0] producto;
    logic        listo;
    logic        ocupado;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int listo_seen = 0;
    int n_pushed = 0;

    logic [15:0] exp_q[$];
    int          cyc_q[$];

    mult_secuencial_shift_add #(.WIDTH(8)) dut (
        .CLK100MHZ     (clk),
        .reset         (reset),
        .inicio        (inicio),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .producto      (producto),
        .listo         (listo),
        .ocupado       (ocupado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp_v, exp_v, cyc);
        end
    endtask

    // Monitor: every listo must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (listo === 1'b1) begin
            listo_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_listo: producto=0x%0h with no start pending, cycle %0d",
                         producto, cyc);
            end else begin
                chk("producto", int'(producto), int'(exp_q.pop_front()));
                chk("listo_cycle", cyc, cyc_q.pop_front());
            end
        end
    end

    // Called at a negedge; the start is taken at the following posedge.
    task automatic start(input logic [7:0] m, input logic [7:0] q, input bit expect_it);
        logic [15:0] mm;
        logic [15:0] qq;
        mm = {8'd0, m};
        qq = {8'd0, q};
        multiplicando = m;
        multiplicador = q;
        inicio = 1'b1;
        if (expect_it) begin
            exp_q.push_back(mm * qq);
            cyc_q.push_back(cyc + 10);
            n_pushed++;
        end
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic wait_listo();
        int n;
        n = 0;
        while (listo !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (listo !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL listo_timeout: listo=%b after %0d cycles, expected 1", listo, n);
        end
    endtask

    initial begin
        reset = 1'b1;
        inicio = 1'b0;
        multiplicando = 8'd0;
        multiplicador = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_producto", int'(producto), 0);
        chk("reset_listo", int'(listo), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of 200*3: no listo may follow.
        start(8'd200, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("calc_ocupado", int'(ocupado), 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_ocupado", int'(ocupado), 0);
        chk("midreset_producto", int'(producto), 0);
        chk("midreset_listo", int'(listo), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_reset_ocupado", int'(ocupado), 0);

        start(8'd255, 8'd255, 1'b1);
        wait_listo();
        @(negedge clk);

        // 5*3: ocupado and held producto checked cycle by cycle.
        start(8'd5, 8'd3, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("busy_ocupado", int'(ocupado), 1);
            chk("busy_listo", int'(listo), 0);
            chk("held_producto", int'(producto), 16'hFE01);
            @(negedge clk);
        end
        chk("done_ocupado", int'(ocupado), 0);
        chk("done_listo", int'(listo), 1);
        @(negedge clk);
        chk("listo_one_cycle", int'(listo), 0);

        start(8'd0, 8'd200, 1'b1);
        wait_listo();
        start(8'd200, 8'd0, 1'b1);
        wait_listo();

        // 12*11 with an ignored second start and operands disturbed mid-CALC.
        start(8'd12, 8'd11, 1'b1);
        @(negedge clk);
        start(8'd7, 8'd7, 1'b0);
        multiplicando = 8'hAA;
        multiplicador = 8'h55;
        wait_listo();

        for (int a = 0; a < 6; a++) begin
            for (int b = 0; b < 6; b++) begin
                start(8'(a), 8'(b), 1'b1);
                wait_listo();
            end
        end
        repeat (15) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("listo_count", listo_seen, n_pushed);
        chk("final_ocupado", int'(ocupado), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
